cordic_arbiter: RTL and testbench



---
 rtl/cordic_arb_pkg.sv | 45 ++++
 rtl/cordic_arbiter_rr_select.sv | 29 ++
 rtl/cordic_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the cordic request arbiter.
// Holds the FSM state encoding, the watchdog width and the round-robin
// search used by rr_select.
package cordic_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  // Watchdog counter width; TIMEOUT_CYCLES must fit in it.
  localparam int unsigned WDOG_W = 8;

  // Largest supported requester count and the index width that covers it.
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned PICK_W  = 4;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // Scan valid[] starting at ptr, wrapping modulo n; the first set bit wins.
  // ptr is expected to be below n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PICK_W-1:0]  ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !res.found && valid[PICK_W'(j)]) begin
        res.found = 1'b1;
        res.idx   = PICK_W'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_select.sv
// Round-robin priority selector: picks the first asserted request at or
// after the pointer, wrapping around. Purely combinational.
module rr_select
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  rr_pick_t pick;

  // Search from the pointer and expand the winner to index and one-hot forms.
  always_comb begin
    pick     = rr_pick(MAX_REQ'(valid_i), PICK_W'(ptr_i), NUM_REQ);
    found_o  = pick.found;
    idx_o    = IDX_W'(pick.idx);
    onehot_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.found && (pick.idx == PICK_W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic between NUM_REQ requesters. Requests are granted
// round-robin, one job is in flight at a time, and each result comes back
// on a single tagged response channel. A watchdog covering WAIT_CLR and
// WAIT_DONE turns a hung cordic into a flagged, zero-data response.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. req_ready is a one-cycle grant pulse computed from
// registered state and req_valid; the requester may drop req_valid at any
// time before it is granted. resp_valid stays high with stable data until
// resp_ready is seen.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_angle,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]           req_mode,
  output logic                         cordic_start,
  output logic [BIT_WIDTH-1:0]         cordic_angle,
  output logic [BIT_WIDTH-1:0]         cordic_x,
  output logic [BIT_WIDTH-1:0]         cordic_y,
  output logic                         cordic_mode,
  input  logic                         cordic_ready,
  input  logic                         cordic_done,
  input  logic [BIT_WIDTH-1:0]         cordic_out_angle,
  input  logic [BIT_WIDTH-1:0]         cordic_out_x,
  input  logic [BIT_WIDTH-1:0]         cordic_out_y,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_WIDTH-1:0]          resp_id,
  output logic [BIT_WIDTH-1:0]         resp_angle,
  output logic [BIT_WIDTH-1:0]         resp_x,
  output logic [BIT_WIDTH-1:0]         resp_y,
  output logic                         resp_timeout,
  output arb_state_t                   dbg_state
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  arb_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     owner_q, owner_d;
  logic [BIT_WIDTH-1:0]    op_angle_q, op_angle_d;
  logic [BIT_WIDTH-1:0]    op_x_q, op_x_d;
  logic [BIT_WIDTH-1:0]    op_y_q, op_y_d;
  logic                    op_mode_q, op_mode_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic [BIT_WIDTH-1:0]    res_angle_q, res_angle_d;
  logic [BIT_WIDTH-1:0]    res_x_q, res_x_d;
  logic [BIT_WIDTH-1:0]    res_y_q, res_y_d;
  logic                    res_timeout_q, res_timeout_d;
  logic                    start_q, start_d;
  logic                    resp_valid_q, resp_valid_d;

  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic [NUM_REQ-1:0]      pick_onehot;
  logic [BIT_WIDTH-1:0]    sel_angle, sel_x, sel_y;
  logic                    sel_mode;
  logic                    wdog_hit;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_WIDTH)
  ) u_rr_select (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign wdog_hit = (wdog_q == WDOG_LIMIT);

  // Route the winning requester's operand slice to the capture registers.
  always_comb begin
    sel_angle = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_mode  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_WIDTH'(i)) begin
        sel_angle = req_angle[i*BIT_WIDTH +: BIT_WIDTH];
        sel_x     = req_x[i*BIT_WIDTH +: BIT_WIDTH];
        sel_y     = req_y[i*BIT_WIDTH +: BIT_WIDTH];
        sel_mode  = req_mode[i];
      end
    end
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      op_angle_q    <= '0;
      op_x_q        <= '0;
      op_y_q        <= '0;
      op_mode_q     <= 1'b0;
      wdog_q        <= '0;
      res_angle_q   <= '0;
      res_x_q       <= '0;
      res_y_q       <= '0;
      res_timeout_q <= 1'b0;
      start_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      op_angle_q    <= op_angle_d;
      op_x_q        <= op_x_d;
      op_y_q        <= op_y_d;
      op_mode_q     <= op_mode_d;
      wdog_q        <= wdog_d;
      res_angle_q   <= res_angle_d;
      res_x_q       <= res_x_d;
      res_y_q       <= res_y_d;
      res_timeout_q <= res_timeout_d;
      start_q       <= start_d;
      resp_valid_q  <= resp_valid_d;
    end
  end

  // Next-state: grant, start handshake, stale-done rejection, completion or
  // watchdog abort, then wait for the response to be taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pick_found) state_d = ISSUE;
      ISSUE:     if (cordic_ready) state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (wdog_hit)          state_d = RESP;
        else if (!cordic_done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as a result.
        if (cordic_done)   state_d = RESP;
        else if (wdog_hit) state_d = RESP;
      end
      RESP:      if (resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs and register next values driven by the current state.
  always_comb begin
    req_ready     = '0;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    op_angle_d    = op_angle_q;
    op_x_d        = op_x_q;
    op_y_d        = op_y_q;
    op_mode_d     = op_mode_q;
    wdog_d        = wdog_q;
    res_angle_d   = res_angle_q;
    res_x_d       = res_x_q;
    res_y_d       = res_y_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so the grant pulse is also silent while held in reset.
        if (pick_found && reset) req_ready = pick_onehot;
        if (pick_found) begin
          owner_d    = pick_idx;
          op_angle_d = sel_angle;
          op_x_d     = sel_x;
          op_y_d     = sel_y;
          op_mode_d  = sel_mode;
          rr_ptr_d   = (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : pick_idx + ID_WIDTH'(1);
        end
      end
      ISSUE: begin
        // Cycles spent waiting for cordic_ready are not charged to the watchdog.
        if (cordic_ready) wdog_d = '0;
      end
      WAIT_CLR: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (wdog_hit) begin
          res_angle_d   = '0;
          res_x_d       = '0;
          res_y_d       = '0;
          res_timeout_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (cordic_done) begin
          res_angle_d   = cordic_out_angle;
          res_x_d       = cordic_out_x;
          res_y_d       = cordic_out_y;
          res_timeout_d = 1'b0;
        end else if (wdog_hit) begin
          res_angle_d   = '0;
          res_x_d       = '0;
          res_y_d       = '0;
          res_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    start_d      = (state_d == ISSUE);
    resp_valid_d = (state_d == RESP);
  end

  assign cordic_start = start_q;
  assign cordic_angle = op_angle_q;
  assign cordic_x     = op_x_q;
  assign cordic_y     = op_y_q;
  assign cordic_mode  = op_mode_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = owner_q;
  assign resp_angle   = res_angle_q;
  assign resp_x       = res_x_q;
  assign resp_y       = res_y_q;
  assign resp_timeout = res_timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter with a small behavioural cordic stub attached.
// The stub's result is a simple deterministic function of its operands so
// expected responses can be computed when a job is queued.
module tb_cordic_arbiter;
  import cordic_arb_pkg::*;

  localparam int BW  = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 10;
  localparam int LAT = 5;
  localparam int LAT_OK = LAT + 1;  // start acceptance to resp_valid, normal job
  localparam int LAT_TO = TO + 1;   // start acceptance to resp_valid, watchdog abort

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid, req_ready, req_mode;
  logic [N*BW-1:0] req_angle, req_x, req_y;
  logic            cordic_start, cordic_mode, cordic_ready, cordic_done;
  logic [BW-1:0]   cordic_angle, cordic_x, cordic_y;
  logic [BW-1:0]   cordic_out_angle, cordic_out_x, cordic_out_y;
  logic            resp_valid, resp_ready, resp_timeout;
  logic [IDW-1:0]  resp_id;
  logic [BW-1:0]   resp_angle, resp_x, resp_y;
  arb_state_t      dbg_state;

  // Requester side: operands per port, pending count = issued - granted.
  logic [BW-1:0] a_angle[N], a_x[N], a_y[N];
  logic          a_mode[N];
  int            issued[N];
  int            granted[N];

  for (genvar g = 0; g < N; g++) begin : g_req
    assign req_angle[g*BW +: BW] = a_angle[g];
    assign req_x[g*BW +: BW]     = a_x[g];
    assign req_y[g*BW +: BW]     = a_y[g];
    assign req_mode[g]           = a_mode[g];
    assign req_valid[g]          = (issued[g] != granted[g]);
  end

  cordic_arbiter #(
    .BIT_WIDTH(BW), .NUM_REQ(N), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_x(cordic_x),
    .cordic_y(cordic_y), .cordic_mode(cordic_mode),
    .cordic_ready(cordic_ready), .cordic_done(cordic_done),
    .cordic_out_angle(cordic_out_angle), .cordic_out_x(cordic_out_x),
    .cordic_out_y(cordic_out_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_angle(resp_angle), .resp_x(resp_x), .resp_y(resp_y),
    .resp_timeout(resp_timeout), .dbg_state(dbg_state)
  );

  // ---------------- cordic stub ----------------
  function automatic logic [3*BW-1:0] stub_fn(logic [BW-1:0] a, logic [BW-1:0] x,
                                             logic [BW-1:0] y, logic m);
    logic [BW-1:0] oa, ox, oy;
    oa = m ? ~a : a + 32'd7;
    ox = x + 32'h0000_0100;
    oy = y ^ a;
    return {oa, ox, oy};
  endfunction

  logic            hang = 1'b0;     // never raise done
  int              stale_hold = 0;  // keep the old done high this many cycles
  logic            m_busy = 1'b0, m_done = 1'b0;
  int              m_cnt = 0, m_hold = 0;
  logic [BW-1:0]   m_a = '0, m_x = '0, m_y = '0;
  logic            m_m = 1'b0;
  logic [3*BW-1:0] m_out = '0;

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_hold > 0) m_hold <= m_hold - 1;
      else            m_done <= 1'b0;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (!hang) begin
          m_done <= 1'b1;
          m_out  <= stub_fn(m_a, m_x, m_y, m_m);
        end
      end
      m_cnt <= m_cnt - 1;
    end else if (cordic_start) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
      m_hold <= stale_hold;
      m_a    <= cordic_angle;
      m_x    <= cordic_x;
      m_y    <= cordic_y;
      m_m    <= cordic_mode;
      if (stale_hold == 0) m_done <= 1'b0;
    end
  end

  assign cordic_ready = !m_busy;
  assign cordic_done  = m_done;
  assign {cordic_out_angle, cordic_out_x, cordic_out_y} = m_out;

  // ---------------- scoreboard ----------------
  logic [IDW+1+3*BW-1:0] exp_q[$];
  int                    exp_grant_q[$];
  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    expired = 0;
  logic                  final_req = 1'b0;
  logic                  final_done = 1'b0;

  logic [N-1:0]          drop = '0;
  logic                  start_prev = 1'b0, resp_prev = 1'b0, held = 1'b0;
  logic [IDW+1+3*BW-1:0] held_w, act, exp_w;
  int                    lat_t = 0, gi, exp_lat;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (drop[i]) granted[i] = granted[i] + 1;
    drop = '0;
    act  = {resp_id, resp_timeout, resp_angle, resp_x, resp_y};
    if (!reset) begin
      n_checks++;
      if ({req_ready, cordic_start, resp_valid, resp_timeout} != '0) begin
        n_errors++;
        $display("FAIL reset_ctrl: ready=%b start=%b valid=%b timeout=%b, required all 0",
                 req_ready, cordic_start, resp_valid, resp_timeout);
      end
      n_checks++;
      if ({cordic_angle, cordic_x, cordic_y, cordic_mode} != '0) begin
        n_errors++;
        $display("FAIL reset_operands: angle=%h x=%h y=%h mode=%b, required 0",
                 cordic_angle, cordic_x, cordic_y, cordic_mode);
      end
      n_checks++;
      if (act != '0) begin
        n_errors++;
        $display("FAIL reset_results: got %h required 0", act);
      end
      start_prev = 1'b0;
      resp_prev  = 1'b0;
      held       = 1'b0;
    end else begin
      // grant monitor
      if (req_ready != '0) begin
        n_checks++;
        gi = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        if ($countones(req_ready) != 1 || exp_grant_q.size() == 0 || resp_valid ||
            gi != exp_grant_q[0] || !req_valid[gi]) begin
          n_errors++;
          $display("FAIL grant: req_ready=%b resp_valid=%b, required port %0d",
                   req_ready, resp_valid,
                   (exp_grant_q.size() > 0) ? exp_grant_q[0] : -1);
        end
        if (exp_grant_q.size() > 0) void'(exp_grant_q.pop_front());
        drop = req_ready;
      end
      // cycles since the cordic accepted start
      if (start_prev && !cordic_start) lat_t = 0;
      else                             lat_t = lat_t + 1;
      // response monitor
      if (resp_valid) begin
        if (!resp_prev && exp_q.size() > 0) begin
          n_checks++;
          exp_lat = exp_q[0][3*BW] ? LAT_TO : LAT_OK;
          if (lat_t != exp_lat) begin
            n_errors++;
            $display("FAIL resp_latency: got %0d cycles required %0d", lat_t, exp_lat);
          end
        end
        if (held) begin
          n_checks++;
          if (act != held_w) begin
            n_errors++;
            $display("FAIL resp_stable: got %h required %h", act, held_w);
          end
        end
        if (resp_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL resp_unexpected: got %h required none", act);
          end else begin
            exp_w = exp_q.pop_front();
            if (act != exp_w) begin
              n_errors++;
              $display("FAIL resp_data: got %h required %h", act, exp_w);
            end
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_w = act;
        end
      end else begin
        held = 1'b0;
      end
      resp_prev  = resp_valid;
      start_prev = cordic_start;
      if (final_req && !final_done) begin
        n_checks++;
        if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
          n_errors++;
          $display("FAIL drain: %0d responses and %0d grants outstanding, required 0",
                   exp_q.size(), exp_grant_q.size());
        end
        n_checks++;
        if (expired != 0) begin
          n_errors++;
          $display("FAIL wait_budget: %0d waits expired, required 0", expired);
        end
        final_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] x,
                        input logic [BW-1:0] y, input logic m);
    a_angle[i] = a;
    a_x[i]     = x;
    a_y[i]     = y;
    a_mode[i]  = m;
  endtask

  task automatic expect_job(input int i, input logic to);
    exp_grant_q.push_back(i);
    if (to) exp_q.push_back({IDW'(i), 1'b1, {(3*BW){1'b0}}});
    else    exp_q.push_back({IDW'(i), 1'b0, stub_fn(a_angle[i], a_x[i], a_y[i], a_mode[i])});
  endtask

  task automatic wait_drain(input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && exp_grant_q.size() == 0) break;
      tick(1);
    end
    if (c == budget) expired++;
  endtask

  task automatic wait_resp_valid(input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      if (resp_valid) break;
      tick(1);
    end
    if (c == budget) expired++;
  endtask

  task automatic wait_state(input arb_state_t s, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      if (dbg_state == s) break;
      tick(1);
    end
    if (c == budget) expired++;
  endtask

  // Per-port operands for the round-robin rounds.
  localparam logic [BW-1:0] T_ANG[N] = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
  localparam logic [BW-1:0] T_X[N]   = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
  localparam logic [BW-1:0] T_Y[N]   = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000, 32'hD000_0000};

  // ---------------- stimulus ----------------
  initial begin
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_op(i, '0, '0, '0, 1'b0);
      issued[i]  = 0;
      granted[i] = 0;
    end
    #1 reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);

    // single request on port 2, then port 3 so the pointer wraps to 0
    set_op(2, 32'h8000_0000, 32'd1304052707, 32'd0, 1'b0);
    expect_job(2, 1'b0);
    issued[2]++;
    wait_drain(200);
    set_op(3, 32'h1234_5678, 32'h0000_0ABC, 32'hFFFF_0000, 1'b1);
    expect_job(3, 1'b0);
    issued[3]++;
    wait_drain(200);

    // all four requesting for three rounds
    for (int i = 0; i < N; i++) set_op(i, T_ANG[i], T_X[i], T_Y[i], i[0]);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) expect_job(i, 1'b0);
    for (int i = 0; i < N; i++) issued[i] += 3;
    wait_drain(600);

    // consumer stalls 20 cycles while a second request waits
    resp_ready = 1'b0;
    set_op(0, 32'h0F0F_0F0F, 32'h0000_1000, 32'h0000_2000, 1'b0);
    set_op(1, 32'h5555_AAAA, 32'h0000_3000, 32'h0000_4000, 1'b1);
    expect_job(0, 1'b0);
    expect_job(1, 1'b0);
    issued[0]++;
    issued[1]++;
    wait_resp_valid(100);
    tick(20);
    resp_ready = 1'b1;
    wait_drain(200);

    // hung cordic: watchdog abort, then a normal job
    hang = 1'b1;
    set_op(3, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0002, 1'b0);
    expect_job(3, 1'b1);
    issued[3]++;
    wait_drain(200);
    hang = 1'b0;
    set_op(2, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 1'b0);
    expect_job(2, 1'b0);
    issued[2]++;
    wait_drain(200);

    // previous done stays high for 3 cycles after start
    stale_hold = 3;
    set_op(0, 32'h7777_0000, 32'h0000_0777, 32'h0070_0000, 1'b1);
    expect_job(0, 1'b0);
    issued[0]++;
    wait_drain(200);
    stale_hold = 0;

    // reset pulse during WAIT_DONE with requests on 1 and 3 pending
    set_op(2, 32'h2222_2222, 32'h0000_0022, 32'h0000_2200, 1'b0);
    exp_grant_q.push_back(2);
    issued[2]++;
    wait_state(WAIT_DONE, 100);
    set_op(1, 32'h1111_0000, 32'h0000_1111, 32'h0001_0001, 1'b0);
    set_op(3, 32'h3333_0000, 32'h0000_3333, 32'h0003_0003, 1'b1);
    expect_job(1, 1'b0);
    expect_job(3, 1'b0);
    issued[1]++;
    issued[3]++;
    tick(1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    wait_drain(300);

    final_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (final_done) break;
      tick(1);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
